sad_accumulator: RTL and testbench

SAD_ACCUMULATOR -- requirements
Module: sad_accumulator

---
 rtl/sad_accumulator.sv | 136 +++++++++++++
 tb/tb_sad_accumulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences engine: captures 16 frame/window word pairs, folds
// LANES pairs per cycle into a saturating accumulator, and tracks the best (minimum) SAD.

module sad_lane (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] d_o
);
  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
endmodule

module sad_accumulator #(
  parameter int LANES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [31:0]  pos_i,
  input  logic [511:0] frame_bus_i,
  input  logic [511:0] window_bus_i,
  input  logic         clear_min_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [31:0]  sad_o,
  output logic [31:0]  min_sad_o,
  output logic [31:0]  min_pos_o,
  output logic         min_valid_o
);
  localparam int         GROUPS = 16 / LANES;
  localparam logic [3:0] LAST   = 4'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t            state_q, state_d;
  logic [15:0][31:0] frame_q, frame_d, win_q, win_d;
  logic [31:0]       pos_q, pos_d, acc_q, acc_d, sad_q, sad_d;
  logic [31:0]       min_sad_q, min_sad_d, min_pos_q, min_pos_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d, min_valid_q, min_valid_d;

  logic [LANES-1:0][31:0] lane_f, lane_w, lane_d;
  logic [36:0]            psum;
  logic [37:0]            total;
  logic [31:0]            acc_sat;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_f[l] = frame_q[4'(int'(cnt_q) * LANES + l)];
    assign lane_w[l] = win_q[4'(int'(cnt_q) * LANES + l)];
    sad_lane u_lane (.a_i(lane_f[l]), .b_i(lane_w[l]), .d_o(lane_d[l]));
  end

  // Wide partial sum so a single saturation step covers both the lane sum and the add.
  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++) psum = psum + 37'(lane_d[l]);
    total   = 38'(acc_q) + 38'(psum);
    acc_sat = (|total[37:32]) ? 32'hFFFF_FFFF : total[31:0];
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    win_d       = win_q;
    pos_d       = pos_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sad_d       = sad_q;
    done_d      = 1'b0;
    min_sad_d   = min_sad_q;
    min_pos_d   = min_pos_q;
    min_valid_d = min_valid_q;
    if (clear_min_i) min_valid_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        frame_d = frame_bus_i;
        win_d   = window_bus_i;
        pos_d   = pos_i;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d = acc_sat;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) state_d = FINISH;
      end
      FINISH: begin
        sad_d   = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
        // A clear on this edge wipes the old minimum before the new result is considered.
        if (!min_valid_q || clear_min_i || acc_q < min_sad_q) begin
          min_sad_d   = acc_q;
          min_pos_d   = pos_q;
          min_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      win_q       <= '0;
      pos_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sad_q       <= '0;
      done_q      <= 1'b0;
      min_sad_q   <= '0;
      min_pos_q   <= '0;
      min_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      win_q       <= win_d;
      pos_q       <= pos_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sad_q       <= sad_d;
      done_q      <= done_d;
      min_sad_q   <= min_sad_d;
      min_pos_q   <= min_pos_d;
      min_valid_q <= min_valid_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign sad_o       = sad_q;
  assign min_sad_o   = min_sad_q;
  assign min_pos_o   = min_pos_q;
  assign min_valid_o = min_valid_q;
endmodule

// File: tb/tb_sad_accumulator.sv
// Directed bench for sad_accumulator (LANES=4): table of full runs plus hand-written corner sequences.
module tb_sad_accumulator;
  logic         clk = 1'b0;
  logic         rst, start, clear_min;
  logic [31:0]  pos;
  logic [511:0] fbus, wbus;
  logic         busy, done, min_valid;
  logic [31:0]  sad, min_sad, min_pos;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sad_accumulator #(.LANES(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pos_i(pos),
    .frame_bus_i(fbus), .window_bus_i(wbus), .clear_min_i(clear_min),
    .busy_o(busy), .done_o(done), .sad_o(sad), .min_sad_o(min_sad),
    .min_pos_o(min_pos), .min_valid_o(min_valid)
  );

  typedef struct {
    int          fk, wk;
    logic [31:0] pos;
    bit          clr_before;
    logic [31:0] exp_sad, exp_min, exp_pos;
    logic        exp_mv;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [511:0] pat(int k);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++)
      case (k)
        0: b[32*i +: 32] = 32'(i * 3 + 1);
        1: b[32*i +: 32] = 32'(i);
        2: b[32*i +: 32] = 32'(15 - i);
        3: b[32*i +: 32] = 32'd0;
        4: b[32*i +: 32] = 32'd5;
        5: b[32*i +: 32] = 32'd8;
        6: b[32*i +: 32] = (i % 2 == 0) ? 32'd11 : 32'd5;
        7: b[32*i +: 32] = 32'hFFFF_FFFF;
        8: b[32*i +: 32] = (i == 0) ? 32'd300 : 32'd0;
        default: b[32*i +: 32] = 32'd0;
      endcase
    return b;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after an edge; the next edge is E0. Buses are scrambled after capture.
  task automatic launch(int fk, int wk, logic [31:0] p);
    start = 1'b1; fbus = pat(fk); wbus = pat(wk); pos = p;
    @(posedge clk); #1;
    start = 1'b0;
    fbus = {16{$urandom()}}; wbus = ~fbus; pos = $urandom();
  endtask

  task automatic wait_done(input bit clr_fin, input bit restart, output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      clear_min = 1'b0; start = 1'b0;
      if (done) lat = c;
      else begin
        if (!busy) busy_ok = 1'b0;
        if (c == 4 && clr_fin) clear_min = 1'b1;
        if (c == 2 && restart) begin
          start = 1'b1; fbus = pat(7); wbus = pat(3); pos = 32'd777;
        end
      end
    end
  endtask

  int lat, ndone;
  bit bok;

  initial begin
    vecs[0] = '{0, 0, 32'd32,  1'b0, 32'd0,        32'd0,   32'd32,  1'b1};
    vecs[1] = '{1, 2, 32'd50,  1'b1, 32'd128,      32'd128, 32'd50,  1'b1};
    vecs[2] = '{3, 4, 32'd100, 1'b1, 32'd80,       32'd80,  32'd100, 1'b1};
    vecs[3] = '{5, 6, 32'd200, 1'b0, 32'd48,       32'd48,  32'd200, 1'b1};
    vecs[4] = '{5, 6, 32'd300, 1'b0, 32'd48,       32'd48,  32'd200, 1'b1};
    vecs[5] = '{7, 3, 32'd400, 1'b0, 32'hFFFFFFFF, 32'd48,  32'd200, 1'b1};

    rst = 1'b1; start = 1'b0; clear_min = 1'b0; pos = '0; fbus = '0; wbus = '0;
    #2;
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_sad", sad, 0);       chk("rst_min", min_sad, 0);
    chk("rst_pos", min_pos, 0);   chk("rst_mv", min_valid, 0);
    @(posedge clk); #1; rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clr_before) begin
        clear_min = 1'b1;
        @(posedge clk); #1; clear_min = 1'b0;
        chk($sformatf("v%0d_clr_mv", v), min_valid, 0);
        chk($sformatf("v%0d_clr_hold", v), min_sad, vecs[v-1].exp_min);
      end
      launch(vecs[v].fk, vecs[v].wk, vecs[v].pos);
      wait_done(1'b0, 1'b0, lat, bok);
      chk($sformatf("v%0d_lat", v), lat, 5);
      chk($sformatf("v%0d_busy", v), bok, 1);
      chk($sformatf("v%0d_sad", v), sad, vecs[v].exp_sad);
      chk($sformatf("v%0d_min", v), min_sad, vecs[v].exp_min);
      chk($sformatf("v%0d_mpos", v), min_pos, vecs[v].exp_pos);
      chk($sformatf("v%0d_mv", v), min_valid, vecs[v].exp_mv);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
    end

    // ClearMin on the FINISH edge installs the new (larger) SAD.
    launch(8, 3, 32'd500);
    wait_done(1'b1, 1'b0, lat, bok);
    chk("cf_sad", sad, 300); chk("cf_min", min_sad, 300);
    chk("cf_pos", min_pos, 500); chk("cf_mv", min_valid, 1);

    // ClearMin alone drops valid but holds the stored values.
    @(posedge clk); #1; clear_min = 1'b1;
    @(posedge clk); #1; clear_min = 1'b0;
    chk("ca_mv", min_valid, 0); chk("ca_min", min_sad, 300); chk("ca_pos", min_pos, 500);

    // Start while busy is ignored.
    launch(1, 2, 32'd600);
    wait_done(1'b0, 1'b1, lat, bok);
    chk("rb_lat", lat, 5); chk("rb_sad", sad, 128); chk("rb_pos", min_pos, 600);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rb_extra_done", ndone, 0);
    chk("rb_sad_hold", sad, 128);

    // Start in the Done cycle is accepted.
    launch(3, 4, 32'd700);
    wait_done(1'b0, 1'b0, lat, bok);
    chk("bb1_sad", sad, 80); chk("bb1_done", done, 1);
    launch(1, 2, 32'd800);
    wait_done(1'b0, 1'b0, lat, bok);
    chk("bb2_lat", lat, 5); chk("bb2_sad", sad, 128);
    chk("bb2_min", min_sad, 80); chk("bb2_pos", min_pos, 700);

    // Reset during ACCUM aborts.
    launch(7, 3, 32'd900);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("ra_busy", busy, 0); chk("ra_done", done, 0); chk("ra_sad", sad, 0);
    chk("ra_min", min_sad, 0); chk("ra_pos", min_pos, 0); chk("ra_mv", min_valid, 0);
    @(posedge clk); #1; rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("ra_no_done", ndone, 0);

    // First run after reset behaves as after power-up.
    launch(3, 4, 32'd1000);
    wait_done(1'b0, 1'b0, lat, bok);
    chk("pr_lat", lat, 5); chk("pr_sad", sad, 80);
    chk("pr_min", min_sad, 80); chk("pr_pos", min_pos, 1000); chk("pr_mv", min_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
